// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Bit-step counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bIn;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (output start, A, B, bIn, input busy, done, diff);
  modport slave  (input start, A, B, bIn, output busy, done, diff);
endinterface

// File: rtl/serial_subtractor_fs.sv
// Combinational 1-bit full subtractor: diff = A - B - bIn, bOut = borrow.
module serial_subtractor_fs (
  input  logic A,
  input  logic B,
  input  logic bIn,
  output logic diff,
  output logic bOut
);
  assign diff = A ^ B ^ bIn;
  assign bOut = (~A & B) | (~(A ^ B) & bIn);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - bIn over WIDTH cycles, one FS cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned RW = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [RW-1:0]    res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   diff_q;
  logic             busy_q, done_q;

  logic             load_c, step_c, busy_d, done_d;
  logic             last_c;
  logic             d_c, bo_c;

  assign last_c = (cnt_q == CW'(WIDTH - 1));

  serial_subtractor_fs u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .bIn  (borrow),
    .diff (d_c),
    .bOut (bo_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_c)    state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode; busy/done are derived from the next state and then registered
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE, DONE: load_c = bus.start;
      SHIFT:      step_c = 1'b1;
      default:    ;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Operand/result datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
    end else if (load_c) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      borrow <= bus.bIn;
      cnt_q  <= '0;
    end else if (step_c) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bo_c;
      cnt_q  <= cnt_q + CW'(1);
      // LSB-first difference bits enter at the top and settle toward bit 0
      res_sr <= (res_sr >> 1) | (RW'(d_c) << (RW - 1));
      if (last_c) diff_q <= {bo_c, d_c, res_sr};
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;

endmodule
